// File: rtl/register_writeback_queue_pkg.sv
// Shared CPU package: register-file geometry and the writeback queue entry type.
package register_writeback_queue_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;
  localparam int COUNT_W   = 4;
  localparam int WBQ_DEPTH = 4;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/register_writeback_queue_forward_match.sv
// Forwarding matcher: returns the youngest pending write to the requested
// register, or the register bank's value when nothing pending matches.
module writeback_forward_match
  import register_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  wb_entry_t [DEPTH-1:0] entries_by_age,
  input  logic [DEPTH-1:0]      valid_by_age,
  input  logic [REG_IDX_W-1:0]  source,
  input  logic [DATA_W-1:0]     bank_out,
  output logic [DATA_W-1:0]     operand
);

  // Walk oldest to youngest so the youngest matching entry (index 0) wins.
  always_comb begin
    operand = bank_out;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_by_age[i] && (entries_by_age[i].dest == source)) begin
        operand = entries_by_age[i].data;
      end
    end
  end

endmodule

// File: rtl/register_writeback_queue.sv
// Writeback queue: buffers register writes in a circular FIFO until the bank
// accepts them, and forwards pending values to the two read ports.
module register_writeback_queue
  import register_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 Wb_valid,
  input  logic [REG_IDX_W-1:0] Wb_dest,
  input  logic [DATA_W-1:0]    Wb_data,
  output logic                 Wb_ready,
  input  logic                 Bank_ready,
  output logic                 Reg_we,
  output logic [REG_IDX_W-1:0] Reg_dest,
  output logic [DATA_W-1:0]    Reg_data,
  input  logic [REG_IDX_W-1:0] Source1,
  input  logic [REG_IDX_W-1:0] Source2,
  input  logic [DATA_W-1:0]    Bank_out_1,
  input  logic [DATA_W-1:0]    Bank_out_2,
  output logic [DATA_W-1:0]    Operand_1,
  output logic [DATA_W-1:0]    Operand_2,
  output logic [COUNT_W-1:0]   Count,
  output logic                 Full,
  output logic                 Empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      slot_valid;
  logic [PTR_W-1:0]      head_ptr;
  logic [PTR_W-1:0]      tail_ptr;
  logic [COUNT_W-1:0]    count_q;

  wb_entry_t [DEPTH-1:0] entries_by_age;
  logic [DEPTH-1:0]      valid_by_age;
  wb_entry_t             head_entry;
  logic                  push;
  logic                  pop;

  // Occupancy flags and handshakes; acceptance ignores any same-cycle drain.
  always_comb begin
    Empty      = (count_q == '0);
    Full       = (count_q == COUNT_W'(DEPTH));
    Count      = count_q;
    Wb_ready   = !Full;
    Reg_we     = !Empty && Bank_ready;
    push       = Wb_valid && Wb_ready;
    pop        = Reg_we;
    head_entry = entries[head_ptr];
    Reg_dest   = Empty ? '0 : head_entry.dest;
    Reg_data   = Empty ? '0 : head_entry.data;
  end

  // Reorder slots youngest-first (index 0 = most recent push) for forwarding.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot           = '0;
    entries_by_age = '0;
    valid_by_age   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot              = tail_ptr - PTR_W'(k + 1);
      entries_by_age[k] = entries[slot];
      valid_by_age[k]   = slot_valid[slot];
    end
  end

  // Pointers, occupancy and slot-valid bits; reset discards anything pending.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count_q    <= '0;
      slot_valid <= '0;
    end else begin
      if (pop) begin
        head_ptr             <= head_ptr + 1'b1;
        slot_valid[head_ptr] <= 1'b0;
      end
      if (push) begin
        tail_ptr             <= tail_ptr + 1'b1;
        slot_valid[tail_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload storage; stale payloads are masked by slot_valid.
  always_ff @(posedge Clock) begin
    if (push) begin
      entries[tail_ptr] <= '{dest: Wb_dest, data: Wb_data};
    end
  end

  writeback_forward_match #(.DEPTH(DEPTH)) u_forward_1 (
    .entries_by_age (entries_by_age),
    .valid_by_age   (valid_by_age),
    .source         (Source1),
    .bank_out       (Bank_out_1),
    .operand        (Operand_1)
  );

  writeback_forward_match #(.DEPTH(DEPTH)) u_forward_2 (
    .entries_by_age (entries_by_age),
    .valid_by_age   (valid_by_age),
    .source         (Source2),
    .bank_out       (Bank_out_2),
    .operand        (Operand_2)
  );

endmodule

// File: tb/tb_register_writeback_queue.sv
// Directed testbench for register_writeback_queue with DEPTH = 4.
module tb_register_writeback_queue;
  import register_writeback_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_dest = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ready;
  logic        bank_ready = 1'b0;
  logic        reg_we;
  logic [3:0]  reg_dest;
  logic [31:0] reg_data;
  logic [3:0]  source1 = '0;
  logic [3:0]  source2 = '0;
  logic [31:0] bank_out_1 = '0;
  logic [31:0] bank_out_2 = '0;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  register_writeback_queue #(.DEPTH(DEPTH)) dut (
    .Clock      (clock),
    .Reset_n    (reset_n),
    .Wb_valid   (wb_valid),
    .Wb_dest    (wb_dest),
    .Wb_data    (wb_data),
    .Wb_ready   (wb_ready),
    .Bank_ready (bank_ready),
    .Reg_we     (reg_we),
    .Reg_dest   (reg_dest),
    .Reg_data   (reg_data),
    .Source1    (source1),
    .Source2    (source2),
    .Bank_out_1 (bank_out_1),
    .Bank_out_2 (bank_out_2),
    .Operand_1  (operand_1),
    .Operand_2  (operand_2),
    .Count      (count),
    .Full       (full),
    .Empty      (empty)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [3:0] dest,
                                input logic [31:0] data, input logic ready);
    wb_valid   = valid;
    wb_dest    = dest;
    wb_data    = data;
    bank_ready = ready;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    wb_entry_t   model_q[$];
    int          pushed;
    int          drained;
    int          cycle;
    logic        exp_ready;
    logic        exp_we;
    wb_entry_t   front;

    // Reset
    tick();
    tick();
    reset_n = 1'b1;
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b1);
    settle();
    check_output("rst_empty", 32'(empty), 32'd1);
    check_output("rst_full", 32'(full), 32'd0);
    check_output("rst_ready", 32'(wb_ready), 32'd1);
    check_output("rst_we", 32'(reg_we), 32'd0);
    check_output("rst_dest", 32'(reg_dest), 32'd0);
    check_output("rst_data", reg_data, 32'd0);
    check_output("rst_count", 32'(count), 32'd0);

    // Single write, one-cycle latency
    apply_stimulus(1'b1, 4'd1, 32'd1, 1'b1);
    settle();
    check_output("single_we_before", 32'(reg_we), 32'd0);
    tick();
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b1);
    settle();
    check_output("single_we", 32'(reg_we), 32'd1);
    check_output("single_dest", 32'(reg_dest), 32'd1);
    check_output("single_data", reg_data, 32'd1);
    check_output("single_count1", 32'(count), 32'd1);
    tick();
    settle();
    check_output("single_count0", 32'(count), 32'd0);
    check_output("single_we_after", 32'(reg_we), 32'd0);

    // Same-cycle incoming write is not forwarded; next cycle it is, while popping
    source1    = 4'd5;
    bank_out_1 = 32'h0000_1234;
    apply_stimulus(1'b1, 4'd5, 32'h0000_DEAD, 1'b1);
    settle();
    check_output("nofwd_incoming", operand_1, 32'h0000_1234);
    tick();
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b1);
    settle();
    check_output("fwd_popping_we", 32'(reg_we), 32'd1);
    check_output("fwd_popping", operand_1, 32'h0000_DEAD);
    tick();
    settle();
    check_output("fwd_after_pop", operand_1, 32'h0000_1234);

    // Fill while bank stalled, reject fifth offer, then drain in order
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 4'(i + 1), 32'd1 << i, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);
    settle();
    check_output("fill_full", 32'(full), 32'd1);
    check_output("fill_ready", 32'(wb_ready), 32'd0);
    check_output("fill_count", 32'(count), 32'd4);
    check_output("fill_we_stalled", 32'(reg_we), 32'd0);
    source1    = 4'd3;
    bank_out_1 = 32'd0;
    settle();
    check_output("fill_fwd_dest3", operand_1, 32'd4);
    apply_stimulus(1'b1, 4'd9, 32'h99, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);
    settle();
    check_output("fifth_count", 32'(count), 32'd4);
    bank_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_output("drain_we", 32'(reg_we), 32'd1);
      check_output("drain_dest", 32'(reg_dest), 32'(i + 1));
      check_output("drain_data", reg_data, 32'd1 << i);
      tick();
    end
    settle();
    check_output("drain_empty", 32'(empty), 32'd1);
    check_output("drain_we_end", 32'(reg_we), 32'd0);
    check_output("stale_fwd_dest3", operand_1, 32'd0);

    // Two pending writes to the same register: youngest forwarded, both written in order
    apply_stimulus(1'b1, 4'd2, 32'd10, 1'b0);
    tick();
    apply_stimulus(1'b1, 4'd2, 32'd20, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);
    source1    = 4'd2;
    bank_out_1 = 32'd0;
    source2    = 4'd3;
    bank_out_2 = 32'd7;
    settle();
    check_output("dup_fwd1", operand_1, 32'd20);
    check_output("dup_fwd2_bank", operand_2, 32'd7);
    source2 = 4'd2;
    settle();
    check_output("dup_fwd2", operand_2, 32'd20);
    bank_ready = 1'b1;
    settle();
    check_output("dup_first", reg_data, 32'd10);
    tick();
    settle();
    check_output("dup_second", reg_data, 32'd20);
    tick();
    settle();
    check_output("dup_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop at Count = 2
    apply_stimulus(1'b1, 4'd6, 32'h60, 1'b0);
    tick();
    apply_stimulus(1'b1, 4'd7, 32'h70, 1'b0);
    tick();
    apply_stimulus(1'b1, 4'd8, 32'h80, 1'b1);
    settle();
    check_output("pp_count_before", 32'(count), 32'd2);
    check_output("pp_dest_before", 32'(reg_dest), 32'd6);
    tick();
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b1);
    settle();
    check_output("pp_count_after", 32'(count), 32'd2);
    check_output("pp_dest_b", 32'(reg_dest), 32'd7);
    check_output("pp_data_b", reg_data, 32'h70);
    tick();
    settle();
    check_output("pp_dest_c", 32'(reg_dest), 32'd8);
    check_output("pp_data_c", reg_data, 32'h80);
    tick();
    settle();
    check_output("pp_empty", 32'(empty), 32'd1);

    // Ten entries streamed through with a stuttering bank, order against a queue model
    pushed  = 0;
    drained = 0;
    cycle   = 0;
    while (((pushed < 10) || (model_q.size() != 0)) && (cycle < 60)) begin
      apply_stimulus(pushed < 10, 4'(pushed + 1), 32'hA000 + 32'(pushed), (cycle % 3) != 0);
      settle();
      exp_ready = model_q.size() < DEPTH;
      exp_we    = (model_q.size() != 0) && bank_ready;
      check_output("wrap_ready", 32'(wb_ready), 32'(exp_ready));
      check_output("wrap_we", 32'(reg_we), 32'(exp_we));
      if (exp_we) begin
        front = model_q.pop_front();
        check_output("wrap_dest", 32'(reg_dest), 32'(front.dest));
        check_output("wrap_data", reg_data, front.data);
        drained++;
      end
      if (wb_valid && exp_ready) begin
        model_q.push_back('{dest: wb_dest, data: wb_data});
        pushed++;
      end
      tick();
      cycle++;
    end
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);
    check_output("wrap_drained", 32'(drained), 32'd10);

    // Reset mid-operation discards pending writes, even with a push offered
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 4'(11 + i), 32'hB0 + 32'(i), 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);
    settle();
    check_output("prerst_count", 32'(count), 32'd3);
    reset_n = 1'b0;
    apply_stimulus(1'b1, 4'd14, 32'hEE, 1'b1);
    tick();
    reset_n = 1'b1;
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b1);
    source1    = 4'd12;
    bank_out_1 = 32'h5555;
    settle();
    check_output("midrst_empty", 32'(empty), 32'd1);
    check_output("midrst_we", 32'(reg_we), 32'd0);
    check_output("midrst_count", 32'(count), 32'd0);
    check_output("midrst_dest", 32'(reg_dest), 32'd0);
    check_output("midrst_fwd", operand_1, 32'h5555);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      check_output("midrst_no_write", 32'(reg_we), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
